// File: rtl/wb_openram_banked.sv
// Wishbone classic slave fronting NUM_BANKS OpenRAM macros on one shared port.
// One request at a time: IDLE -> ACCESS -> (WAIT) -> ACK, or IDLE -> ERR for
// addresses outside the window. RAM controls are registered and only active
// during the single ACCESS cycle.
module wb_openram_banked #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          ADDR_WIDTH   = 9,
    parameter int          NUM_BANKS    = 2,
    parameter int          READ_LATENCY = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic                      wbs_err_o,
    output logic [NUM_BANKS-1:0]      ram_csb0,
    output logic                      ram_web0,
    output logic [3:0]                ram_wmask0,
    output logic [ADDR_WIDTH-1:0]     ram_addr0,
    output logic [31:0]               ram_din0,
    input  logic [32*NUM_BANKS-1:0]   ram_dout0
);

    localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int TAG_LSB   = ADDR_WIDTH + 2 + BANK_BITS;

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, ACK, ERR} state_t;

    state_t                state;
    logic [BW-1:0]         req_bank;
    logic [BW-1:0]         bank_q;
    logic                  we_q;
    logic [1:0]            wait_cnt;
    logic                  in_window;
    logic [NUM_BANKS-1:0]  sel_csb;
    logic [ADDR_WIDTH-1:0] req_word;

    // Byte offset bits never select anything.
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[1:0];

    generate
        if (BANK_BITS > 0) begin : g_bank
            assign req_bank = wbs_adr_i[ADDR_WIDTH+1+BANK_BITS:ADDR_WIDTH+2];
        end else begin : g_nobank
            assign req_bank = '0;
        end
    endgenerate

    assign req_word  = wbs_adr_i[ADDR_WIDTH+1:2];
    assign in_window = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

    // One-cold chip select for the addressed bank.
    always_comb begin
        sel_csb = '1;
        for (int b = 0; b < NUM_BANKS; b++)
            sel_csb[b] = (req_bank != BW'(b));
    end

    // Transaction FSM; every output is registered here.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            wbs_dat_o  <= '0;
            ram_csb0   <= '1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= '0;
            ram_addr0  <= '0;
            ram_din0   <= '0;
            wait_cnt   <= '0;
            bank_q     <= '0;
            we_q       <= 1'b0;
        end else begin
            // RAM controls fall back to idle after the single ACCESS cycle.
            ram_csb0   <= '1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        if (in_window) begin
                            state     <= ACCESS;
                            ram_csb0  <= sel_csb;
                            ram_addr0 <= req_word;
                            bank_q    <= req_bank;
                            we_q      <= wbs_we_i;
                            if (wbs_we_i) begin
                                // An all-zero select still completes, but never writes.
                                ram_web0   <= (wbs_sel_i == 4'b0000);
                                ram_wmask0 <= wbs_sel_i;
                                ram_din0   <= wbs_dat_i;
                            end
                        end else begin
                            state     <= ERR;
                            wbs_ack_o <= 1'b1;
                            wbs_err_o <= 1'b1;
                            wbs_dat_o <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!wbs_cyc_i) begin
                        state <= IDLE;
                    end else if (we_q) begin
                        state     <= ACK;
                        wbs_ack_o <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 2'(READ_LATENCY);
                    end
                end
                WAIT: begin
                    if (!wbs_cyc_i) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == 2'd1) begin
                        state     <= ACK;
                        wait_cnt  <= '0;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= ram_dout0[{bank_q, 5'd0} +: 32];
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ACK:     state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_openram_banked.sv
// Directed bench for wb_openram_banked with a behavioural two-bank RAM.
// Stimulus pushes expected acks into a scoreboard; a negedge monitor pops
// and compares ack timing, err and read data.
module tb_wb_openram_banked;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o, wbs_err_o;
    logic [31:0] wbs_dat_o;
    logic [1:0]  ram_csb0;
    logic        ram_web0;
    logic [3:0]  ram_wmask0;
    logic [7:0]  ram_addr0;
    logic [31:0] ram_din0;
    logic [63:0] ram_dout0 = '0;

    wb_openram_banked #(
        .BASE_ADDR(32'h3000_0000), .ADDR_WIDTH(8), .NUM_BANKS(2), .READ_LATENCY(1)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .wbs_err_o(wbs_err_o),
        .ram_csb0(ram_csb0), .ram_web0(ram_web0), .ram_wmask0(ram_wmask0),
        .ram_addr0(ram_addr0), .ram_din0(ram_din0), .ram_dout0(ram_dout0)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc_cnt = 0;
    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    // Behavioural OpenRAM: one-cycle read latency, byte-masked writes.
    logic [31:0] mem [2][256];
    initial for (int b = 0; b < 2; b++) for (int w = 0; w < 256; w++) mem[b][w] = '0;
    always @(posedge wb_clk_i) begin
        for (int b = 0; b < 2; b++) begin
            if (!ram_csb0[b]) begin
                if (!ram_web0) begin
                    for (int i = 0; i < 4; i++)
                        if (ram_wmask0[i]) mem[b][ram_addr0][8*i +: 8] <= ram_din0[8*i +: 8];
                end else begin
                    ram_dout0[32*b +: 32] <= mem[b][ram_addr0];
                end
            end
        end
    end

    int npass = 0;
    int ntot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        ntot++;
        if (act === exp_v) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp_v);
    endtask

    typedef struct {
        int          cyc;
        logic        err;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge wb_clk_i) begin
        if (wbs_ack_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
                chk("ack_err", {31'd0, wbs_err_o}, {31'd0, mon_e.err});
                if (mon_e.chk_dat) chk("ack_rdata", wbs_dat_o, mon_e.dat);
            end
        end
    end

    // One Wishbone transfer; snapshots the RAM controls of any access cycle.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] edat, input logic eerr,
                        input int lat, output logic [1:0] acsb, output logic aweb,
                        output logic [3:0] awm, output logic [7:0] aaddr,
                        output logic [31:0] adin, output int nacc);
        exp_t e;
        bit   got;
        got = 0;
        @(posedge wb_clk_i); #1;
        e.cyc = cyc_cnt + lat; e.err = eerr; e.chk_dat = !we || eerr; e.dat = edat;
        sb.push_back(e);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        nacc = 0; acsb = 2'b11; aweb = 1; awm = 0; aaddr = 0; adin = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge wb_clk_i);
            if (ram_csb0 != 2'b11) begin
                nacc++;
                acsb = ram_csb0; aweb = ram_web0; awm = ram_wmask0;
                aaddr = ram_addr0; adin = ram_din0;
            end
            if (wbs_ack_o) got = 1;
        end
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        if (!got) begin
            chk("ack_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end
    endtask

    task automatic count_acks(input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) acks++;
        end
    endtask

    logic [1:0]  c;
    logic        w;
    logic [3:0]  m;
    logic [7:0]  a;
    logic [31:0] d;
    int          n;

    initial begin
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;

        // Asynchronous reset, checked before any clock edge.
        #2 wb_rst_i = 1;
        #1;
        chk("rst_ack",   {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_err",   {31'd0, wbs_err_o}, 32'd0);
        chk("rst_dat",   wbs_dat_o, 32'd0);
        chk("rst_csb",   {30'd0, ram_csb0}, 32'd3);
        chk("rst_web",   {31'd0, ram_web0}, 32'd1);
        chk("rst_wmask", {28'd0, ram_wmask0}, 32'd0);
        chk("rst_addr",  {24'd0, ram_addr0}, 32'd0);
        chk("rst_din",   ram_din0, 32'd0);
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 0;

        // Preload bank0 word 2.
        xfer(1, 32'h3000_0008, 32'h1122_3344, 4'hF, 0, 0, 2, c, w, m, a, d, n);
        chk("pre_csb", {30'd0, c}, 32'd2);
        chk("pre_nacc", 32'(n), 32'd1);

        // Write bank1 word 1.
        xfer(1, 32'h3000_0404, 32'hCAFE_F00D, 4'hF, 0, 0, 2, c, w, m, a, d, n);
        chk("wr_csb",   {30'd0, c}, 32'd1);
        chk("wr_addr",  {24'd0, a}, 32'h01);
        chk("wr_web",   {31'd0, w}, 32'd0);
        chk("wr_wmask", {28'd0, m}, 32'hF);
        chk("wr_din",   d, 32'hCAFE_F00D);
        chk("wr_nacc",  32'(n), 32'd1);

        // Read back the preload, then a single-byte write and re-read.
        xfer(0, 32'h3000_0008, 0, 4'hF, 32'h1122_3344, 0, 3, c, w, m, a, d, n);
        chk("rd0_csb", {30'd0, c}, 32'd2);
        xfer(1, 32'h3000_0008, 32'h0000_00AA, 4'b0001, 0, 0, 2, c, w, m, a, d, n);
        chk("bw_wmask", {28'd0, m}, 32'h1);
        chk("bw_csb",   {30'd0, c}, 32'd2);
        xfer(0, 32'h3000_0008, 0, 4'hF, 32'h1122_33AA, 0, 3, c, w, m, a, d, n);

        // Bank1 read; bank0 output now holds different data.
        xfer(0, 32'h3000_0404, 0, 4'hF, 32'hCAFE_F00D, 0, 3, c, w, m, a, d, n);
        chk("rd_csb",   {30'd0, c}, 32'd1);
        chk("rd_web",   {31'd0, w}, 32'd1);
        chk("rd_wmask", {28'd0, m}, 32'd0);
        chk("rd_addr",  {24'd0, a}, 32'h01);

        // Read data holds across a write.
        xfer(1, 32'h3000_000C, 32'h5555_5555, 4'hF, 0, 0, 2, c, w, m, a, d, n);
        @(negedge wb_clk_i);
        chk("dat_hold", wbs_dat_o, 32'hCAFE_F00D);

        // Out-of-window access.
        xfer(0, 32'h3000_1000, 0, 4'hF, 32'd0, 1, 1, c, w, m, a, d, n);
        chk("oow_nacc", 32'(n), 32'd0);

        // Zero-select write: accessed, acked, but nothing stored.
        xfer(1, 32'h3000_0404, 32'hFFFF_FFFF, 4'h0, 0, 0, 2, c, w, m, a, d, n);
        chk("sel0_nacc",  32'(n), 32'd1);
        chk("sel0_web",   {31'd0, w}, 32'd1);
        chk("sel0_wmask", {28'd0, m}, 32'd0);
        xfer(0, 32'h3000_0404, 0, 4'hF, 32'hCAFE_F00D, 0, 3, c, w, m, a, d, n);

        // Abort: drop cyc while in WAIT.
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0008;
        @(posedge wb_clk_i);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0;
        count_acks(6, n);
        chk("abort_no_ack", 32'(n), 32'd0);
        xfer(1, 32'h3000_0000, 32'h0BAD_F00D, 4'hF, 0, 0, 2, c, w, m, a, d, n);
        chk("post_abort_csb",  {30'd0, c}, 32'd2);
        chk("post_abort_addr", {24'd0, a}, 32'd0);

        // Reset during ACCESS.
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0404; wbs_dat_i = 32'hDEAD_BEEF;
        @(posedge wb_clk_i); #1;
        chk("rst_mid_pre_csb", {30'd0, ram_csb0}, 32'd1);
        wb_rst_i = 1;
        #1;
        chk("rst_mid_csb", {30'd0, ram_csb0}, 32'd3);
        chk("rst_mid_ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst_mid_web", {31'd0, ram_web0}, 32'd1);
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 0;
        count_acks(6, n);
        chk("rst_no_ack", 32'(n), 32'd0);
        xfer(0, 32'h3000_0404, 0, 4'hF, 32'hCAFE_F00D, 0, 3, c, w, m, a, d, n);

        repeat (3) @(negedge wb_clk_i);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/wb_openram_banked.md
WB_OPENRAM_BANKED -- requirements
Module: wb_openram_banked

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000: byte base address of the window, aligned to the window size.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9: word-address width per bank.
REQ-003 SHALL have parameter NUM_BANKS, default 2: number of OpenRAM macros, a power of 2 in 1..8; BANK_BITS = log2(NUM_BANKS).
REQ-004 SHALL have parameter READ_LATENCY, default 1: cycles from the RAM access edge to valid ram_dout0, range 1..3.
REQ-005 SHALL have wb_clk_i  in  1  sole clock; the design is posedge only.
REQ-006 SHALL have wb_rst_i  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic strobe, cycle and write.
REQ-008 SHALL have wbs_sel_i  in  4  byte lane selects.
REQ-009 SHALL have wbs_adr_i and wbs_dat_i  in  32 each  byte address and write data.
REQ-010 SHALL have wbs_ack_o  out  1  registered acknowledge.
REQ-011 SHALL have wbs_dat_o  out  32  registered read data.
REQ-012 SHALL have wbs_err_o  out  1  one-cycle pulse for an out-of-window access.
REQ-013 SHALL have ram_csb0  out  NUM_BANKS  per-bank chip select, active-low.
REQ-014 SHALL have ram_web0  out  1  shared write enable, active-low.
REQ-015 SHALL have ram_wmask0  out  4  shared write mask.
REQ-016 SHALL have ram_addr0  out  ADDR_WIDTH  shared word address.
REQ-017 SHALL have ram_din0  out  32  shared write data.
REQ-018 SHALL have ram_dout0  in  32*NUM_BANKS  read data, with bank b on bits [32b+31:32b].

Function
REQ-019 SHALL decode the address as: word = adr[ADDR_WIDTH+1:2]; bank = adr[ADDR_WIDTH+1+BANK_BITS:ADDR_WIDTH+2]; in-window when adr[31:ADDR_WIDTH+2+BANK_BITS] equals the same bits of BASE_ADDR; adr[1:0] ignored.
REQ-020 SHALL implement FSM states IDLE, ACCESS, WAIT, ACK, ERR.
REQ-021 SHALL, in IDLE with cyc & stb sampled high and in-window, register the RAM controls and go to ACCESS.
  - ram_csb0[bank]=0, other csb bits 1; ram_addr0=word.
  - Write: ram_web0=0, ram_wmask0=sel, ram_din0=dat_i. If sel==0, web stays 1 and the RAM is not written, but the access is still acked.
  - Read: ram_web0=1, ram_wmask0=0.
REQ-022 SHALL latch the bank index at request acceptance.
REQ-023 SHALL, in IDLE with an out-of-window request, go to ERR and leave all csb bits high.
REQ-024 SHALL hold RAM controls active only during the single ACCESS cycle; in every other state csb is all-ones, web=1, wmask=0.
REQ-025 SHALL transition ACCESS -> ACK for a write and ACCESS -> WAIT for a read.
REQ-026 SHALL stay in WAIT exactly READ_LATENCY cycles, using a down-counter loaded on entry.
REQ-027 SHALL, on the edge leaving WAIT, capture the latched bank's ram_dout0 slice into wbs_dat_o, then go to ACK.
REQ-028 SHALL assert wbs_ack_o for exactly one cycle in ACK, gated by wbs_cyc_i, then return to IDLE.
REQ-029 SHALL, in ERR, assert wbs_ack_o and wbs_err_o for one cycle, load wbs_dat_o=0, and return to IDLE.
REQ-030 SHALL give these latencies from the request-sampling edge to the ack cycle: write 2 cycles, read 2+READ_LATENCY cycles, error 1 cycle.
REQ-031 SHALL, if wbs_cyc_i falls during ACCESS or WAIT, complete the RAM operation, suppress the ack, and return to IDLE without an ack.
REQ-032 SHALL ignore a request in the IDLE cycle directly after ACK/ERR unless stb is still high; back-to-back requests are accepted from IDLE with no extra gap.
REQ-033 SHALL hold wbs_dat_o between reads and change it only on a read capture or an ERR.

Reset
REQ-034 SHALL, while wb_rst_i is high, immediately force state=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, ram_csb0 all-ones, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, and WAIT counter=0.
REQ-035 SHALL, on reset mid-transaction, issue no ack after release and accept the next request normally.

Verification
All scenarios use NUM_BANKS=2, ADDR_WIDTH=8, READ_LATENCY=1, BASE_ADDR=0x3000_0000, with a behavioural RAM model.
REQ-036 SHALL verify a write: adr 0x3000_0404, dat 0xCAFEF00D, sel F -> one ACCESS cycle with csb=2'b01, addr=0x01, web=0, wmask=F; ack 2 cycles after request.
REQ-037 SHALL verify a read: read of 0x3000_0404 -> csb=2'b01, web=1; ack 3 cycles after request; wbs_dat_o=0xCAFEF00D; bank0 data ignored.
REQ-038 SHALL verify a byte write: write 0x000000AA sel 4'b0001 to 0x3000_0008, after that word held 0x11223344 -> read returns 0x112233AA; bank0 only.
REQ-039 SHALL verify an out-of-window access: read 0x3000_1000 -> ack and err next cycle, wbs_dat_o=0, csb stays 2'b11 throughout.
REQ-040 SHALL verify abort: cyc dropped in WAIT -> no ack; the next write to 0x3000_0000 is acked 2 cycles after request.
REQ-041 SHALL verify reset: wb_rst_i asserted in ACCESS -> csb=2'b11, ack=0 asynchronously; no ack after release.
